noise_test_sequencer: RTL and testbench
=======================================

# noise_test_sequencer

Sequences one bit-error-rate run of the noise tester from a single 50 MHz clock. It launches a transmit bit pattern at a fixed bit rate and samples the returned bit at a programmable mid-bit offset. Each sample is compared against the bit that was sent, and mismatches are counted over a requested number of bits. It sits between the host control logic, which issues start/abort and reads the results, and the channel under test, which carries tx_bit out and rx_bit back.

## Interface
- BIT_CYCLES, 250: clk cycles per bit (200 kHz bit rate at 50 MHz); legal values ≥ 2.
- SAMPLE_OFFSET, 125: phase within the bit at which rx_bit is sampled; legal range 0..BIT_CYCLES-1.
- ERR_W, 16: width of the error counter.
- clk  in  1  system clock, 50 MHz; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin a run; honoured only in IDLE.
- abort  in  1  ends a run immediately; honoured only in RUN.
- num_bits  in  16  number of bits to send and check; latched on an accepted start.
- rx_bit  in  1  returned bit from the channel; already synchronised to clk.
- tx_bit  out  1  transmit bit to the channel.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when a run completes normally.
- err_count  out  ERR_W  mismatches counted in the current or last run.
- err_sat  out  1  err_count reached all-ones during the run.
- bit_count  out  16  bits sampled so far in the current or last run.

## Operation
- States: IDLE, RUN, DONE.
- Reset: IDLE; tx_bit=0, busy=0, done=0, err_count=0, err_sat=0, bit_count=0, phase=0.
- Accepted start (IDLE, start=1):
  - Latches num_bits.
  - Clears err_count, err_sat, bit_count and phase; loads the pattern seed.
  - If num_bits=0, next state is DONE; otherwise next state is RUN.
- RUN:
  - phase counts 0..BIT_CYCLES-1 and wraps to 0.
  - Launch at phase=0: tx_bit takes the next pattern bit. The first bit appears on entry to RUN.
  - Sample at phase=SAMPLE_OFFSET: mismatch = rx_bit XOR tx_bit.
  - On each sample, bit_count increments by 1.
  - On a mismatch, err_count increments by 1, saturating at 2^ERR_W-1. err_sat sets when err_count reaches that value.
  - A sample and a launch never coincide unless SAMPLE_OFFSET=0. In that case the sample uses the tx_bit value from before that launch's update.
  - When the sample takes bit_count to num_bits, next state is DONE.
- abort in RUN:
  - Next state is IDLE; done is not pulsed.
  - err_count, err_sat and bit_count hold their partial values.
  - abort takes priority over a same-cycle final sample: that sample is not counted.
- DONE: done=1 for exactly one cycle, then IDLE.
- IDLE:
  - tx_bit=0.
  - Results hold until the next accepted start.
  - start in RUN or DONE is ignored; abort in IDLE or DONE is ignored.
- rst at any time: immediate return to reset values; an in-progress run is discarded.

## Timing
- Start accepted at cycle t:
  - busy=1 and the first tx_bit are valid at t+1.
  - Bit k (k = 0..N-1) launches at t+1+k·BIT_CYCLES.
  - Bit k is sampled at t+1+k·BIT_CYCLES+SAMPLE_OFFSET.
  - done pulses at t+2+(N-1)·BIT_CYCLES+SAMPLE_OFFSET; busy drops in the same cycle.
- N=0: done pulses at t+1; busy stays 0.
- err_count and bit_count update one cycle after their sample edge.
- abort at cycle a: busy=0 and tx_bit=0 at a+1.

## Configuration
- PRBS_EN defined:
  - tx pattern is PRBS7, x^7+x^6+1, from a 7-bit LFSR seeded to 7'h7F on start.
  - Output bit = lfsr[6]; next lfsr = {lfsr[5:0], lfsr[6]^lfsr[5]}.
  - The LFSR advances after each launch.
- PRBS_EN undefined:
  - tx pattern alternates 1,0,1,0,…, starting with 1.
  - No LFSR is instantiated.

## Test plan
- Loopback (rx_bit=tx_bit), num_bits=100, defaults: err_count=0, bit_count=100, done exactly at t+24877, single-cycle pulse.
- Inverted loopback (rx_bit=~tx_bit), num_bits=10: err_count=10, err_sat=0; first sample at t+126.
- num_bits=0: done at t+1, busy never high, err_count=0, tx_bit stays 0.
- ERR_W=4, inverted loopback, num_bits=20: err_count=15, err_sat=1, bit_count=20.
- Inverted loopback, abort asserted after the 5th sample: busy=0 next cycle, no done, err_count=5, bit_count=5; a start issued during the run was ignored.
- PRBS_EN defined, loopback: first 8 tx bits 1,1,1,1,1,1,1,0. rst asserted mid-run: all outputs return to reset values in the same cycle, and a new start runs normally.

Source files
------------

// File: rtl/noise_test_sequencer.sv
// noise_test_sequencer
//
// Sequences one bit-error-rate run. A transmit pattern is launched one bit
// every BIT_CYCLES clocks; the returned bit is sampled SAMPLE_OFFSET clocks
// into each bit and compared with the bit that was sent. Mismatches are
// counted (saturating) over num_bits bits.
//
// Optional feature macro: PRBS_EN
//   defined   -> PRBS7 (x^7+x^6+1) pattern from a 7-bit LFSR seeded to 7'h7F
//   undefined -> alternating 1,0,1,0,... pattern, no LFSR
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst        asynchronous active-high reset
//   start      one-cycle run request, honoured only when idle
//   abort      ends a run immediately, honoured only while running
//   num_bits   bits to send/check, latched on an accepted start
//   rx_bit     returned bit, already synchronised to clk
//   tx_bit     transmit bit (0 whenever not running)
//   busy       high while running
//   done       one-cycle pulse on normal completion
//   err_count  mismatches in the current/last run (saturating)
//   err_sat    err_count reached all-ones during the run
//   bit_count  bits sampled in the current/last run
module noise_test_sequencer #(
  parameter int BIT_CYCLES    = 250,
  parameter int SAMPLE_OFFSET = 125,
  parameter int ERR_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [15:0]      num_bits,
  input  logic             rx_bit,
  output logic             tx_bit,
  output logic             busy,
  output logic             done,
  output logic [ERR_W-1:0] err_count,
  output logic             err_sat,
  output logic [15:0]      bit_count
);

  localparam int PHASE_W = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [PHASE_W-1:0] PHASE_LAST   = PHASE_W'(BIT_CYCLES - 1);
  localparam logic [PHASE_W-1:0] PHASE_SAMPLE = PHASE_W'(SAMPLE_OFFSET);
  localparam logic [ERR_W-1:0]   ERR_MAX      = '1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_reg, state_next;
  logic [15:0]        num_bits_reg;
  logic [PHASE_W-1:0] phase_reg;
  logic               tx_reg;
  logic [ERR_W-1:0]   err_count_reg;
  logic               err_sat_reg;
  logic [15:0]        bit_count_reg;

  logic accept, in_run, launch, sample, mismatch, last_sample;
  logic first_bit, next_bit;

  assign accept   = (state_reg == IDLE) && start;
  assign in_run   = (state_reg == RUN);
  // tx_reg is reloaded on the last phase so the new bit is visible at phase 0.
  assign launch   = in_run && (phase_reg == PHASE_LAST);
  // abort wins over a coincident sample: that sample is dropped.
  assign sample   = in_run && !abort && (phase_reg == PHASE_SAMPLE);
  assign mismatch = rx_bit ^ tx_reg;
  assign last_sample = sample &&
                       (({1'b0, bit_count_reg} + 17'd1) == {1'b0, num_bits_reg});

`ifdef PRBS_EN
  localparam logic [6:0] PRBS_SEED = 7'h7F;
  logic [6:0] lfsr_reg, lfsr_next;

  // The seed's own output bit goes out on entry to RUN, so the register
  // starts one step ahead of it and advances after every later launch.
  always_comb begin
    lfsr_next = lfsr_reg;
    if (accept)
      lfsr_next = {PRBS_SEED[5:0], PRBS_SEED[6] ^ PRBS_SEED[5]};
    else if (launch)
      lfsr_next = {lfsr_reg[5:0], lfsr_reg[6] ^ lfsr_reg[5]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_reg <= PRBS_SEED;
    else     lfsr_reg <= lfsr_next;
  end

  assign first_bit = PRBS_SEED[6];
  assign next_bit  = lfsr_reg[6];
`else
  assign first_bit = 1'b1;
  assign next_bit  = ~tx_reg;
`endif

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start) state_next = (num_bits == 16'd0) ? DONE : RUN;
      RUN: begin
        if (abort)            state_next = IDLE;
        else if (last_sample) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_bits_reg  <= '0;
      phase_reg     <= '0;
      tx_reg        <= 1'b0;
      err_count_reg <= '0;
      err_sat_reg   <= 1'b0;
      bit_count_reg <= '0;
    end else if (accept) begin
      num_bits_reg  <= num_bits;
      phase_reg     <= '0;
      tx_reg        <= first_bit;
      err_count_reg <= '0;
      err_sat_reg   <= 1'b0;
      bit_count_reg <= '0;
    end else if (in_run) begin
      phase_reg <= (phase_reg == PHASE_LAST) ? '0 : phase_reg + PHASE_W'(1);
      if (launch) tx_reg <= next_bit;
      if (sample) begin
        bit_count_reg <= bit_count_reg + 16'd1;
        if (mismatch && (err_count_reg != ERR_MAX)) begin
          err_count_reg <= err_count_reg + ERR_W'(1);
          if (err_count_reg == ERR_MAX - ERR_W'(1)) err_sat_reg <= 1'b1;
        end
      end
    end
  end

  assign busy      = in_run;
  assign done      = (state_reg == DONE);
  assign tx_bit    = in_run & tx_reg;
  assign err_count = err_count_reg;
  assign err_sat   = err_sat_reg;
  assign bit_count = bit_count_reg;

endmodule

// File: tb/tb_noise_test_sequencer.sv
`timescale 1ns/1ps
module tb_noise_test_sequencer;

  localparam int BC  = 250, SO  = 125;
  localparam int BC4 = 3,   SO4 = 0, EW4 = 4;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic        rst = 1'b1, st = 1'b0, ab = 1'b0, sel = 1'b0, cur_flip = 1'b0;
  logic [15:0] nb = '0;

  logic start_m, abort_m, rx_m, tx_m, busy_m, done_m, sat_m;
  logic [15:0] err_m, bits_m;
  logic start_s, abort_s, rx_s, tx_s, busy_s, done_s, sat_s;
  logic [EW4-1:0] err_s;
  logic [15:0] bits_s;

  assign start_m = st & ~sel;
  assign abort_m = ab & ~sel;
  assign start_s = st & sel;
  assign abort_s = ab & sel;
  // Channel model: loopback with a per-bit inversion chosen by the bench.
  assign rx_m = tx_m ^ cur_flip;
  assign rx_s = tx_s ^ cur_flip;

  noise_test_sequencer dut_main (
    .clk(clk), .rst(rst), .start(start_m), .abort(abort_m), .num_bits(nb),
    .rx_bit(rx_m), .tx_bit(tx_m), .busy(busy_m), .done(done_m),
    .err_count(err_m), .err_sat(sat_m), .bit_count(bits_m));

  noise_test_sequencer #(.BIT_CYCLES(BC4), .SAMPLE_OFFSET(SO4), .ERR_W(EW4)) dut_small (
    .clk(clk), .rst(rst), .start(start_s), .abort(abort_s), .num_bits(nb),
    .rx_bit(rx_s), .tx_bit(tx_s), .busy(busy_s), .done(done_s),
    .err_count(err_s), .err_sat(sat_s), .bit_count(bits_s));

  logic o_tx, o_busy, o_done, o_sat;
  logic [15:0] o_err, o_bits;
  always_comb begin
    o_tx = tx_m; o_busy = busy_m; o_done = done_m; o_sat = sat_m;
    o_err = err_m; o_bits = bits_m;
    if (sel) begin
      o_tx = tx_s; o_busy = busy_s; o_done = done_s; o_sat = sat_s;
      o_err = {12'd0, err_s}; o_bits = bits_s;
    end
  end

  int n_cmp = 0, n_bad = 0;
  int cbc, cso, cmax;
  bit flip [0:127];
  bit pat_tab [0:127];

  // expected results from the model
  int exp_done_c, exp_end_c, exp_done_cnt, exp_err, exp_bits;
  bit exp_sat;
  // captured results
  int cap_done_cnt, cap_done_c, cap_busy_bad, cap_tx_bad, cap_err, cap_bits, cap_first0, cap_first1;
  bit cap_sat;

  task automatic select_dut(input bit s);
    sel  = s;
    cbc  = s ? BC4 : BC;
    cso  = s ? SO4 : SO;
    cmax = s ? (1 << EW4) - 1 : 65535;
  endtask

  task automatic build_pattern();
`ifdef PRBS_EN
    logic [6:0] lf;
    lf = 7'h7F;
    for (int k = 0; k < 128; k++) begin
      pat_tab[k] = lf[6];
      lf = {lf[5:0], lf[6] ^ lf[5]};
    end
`else
    for (int k = 0; k < 128; k++) pat_tab[k] = (k % 2) == 0;
`endif
  endtask

  task automatic set_flips(input int mode);  // 0 loopback, 1 inverted, 2 random
    for (int k = 0; k < 128; k++) flip[k] = (mode == 2) ? bit'($urandom_range(0, 1)) : bit'(mode);
  endtask

  // Reference model: timing from the bit schedule, counts from the flip table.
  task automatic model(input int n, input int abort_c);
    bit aborted;
    int mism, cnt, s;
    exp_done_c   = (n == 0) ? 1 : 2 + (n - 1) * cbc + cso;
    aborted      = (n > 0) && (abort_c > 0) && (abort_c < exp_done_c);
    exp_end_c    = aborted ? abort_c + 1 : exp_done_c;
    exp_done_cnt = aborted ? 0 : 1;
    mism = 0; cnt = 0;
    for (int k = 0; k < n; k++) begin
      s = 1 + k * cbc + cso;
      if (!aborted || s < abort_c) begin
        cnt++;
        mism += int'(flip[k]);
      end
    end
    exp_bits = cnt;
    exp_err  = (mism > cmax) ? cmax : mism;
    exp_sat  = (mism >= cmax);
  endtask

  // Drives one run (start at cycle t, c counts cycles after t) and records
  // what the selected DUT did. abort_c/start_c = 0 means not used.
  task automatic run_case(input int n, input int abort_c, input int start_c);
    int k;
    bit e_busy, e_tx;
    @(posedge clk); #1;
    st = 1'b1; nb = 16'(n); ab = 1'b0;
    @(posedge clk); #1;
    st = 1'b0;
    cap_done_cnt = 0; cap_done_c = -1; cap_busy_bad = 0; cap_tx_bad = 0;
    cap_first0 = -1; cap_first1 = -1;
    for (int c = 1; c <= exp_end_c + 3; c++) begin
      k = (c - 1) / cbc;
      if (k > 127) k = 127;
      cur_flip = flip[k];
      ab = (c == abort_c);
      st = (c == start_c);
      e_busy = (c < exp_end_c);
      e_tx   = e_busy ? pat_tab[k] : 1'b0;
      if (o_busy !== e_busy) cap_busy_bad++;
      if (o_tx !== e_tx) cap_tx_bad++;
      if (o_done === 1'b1) begin cap_done_cnt++; cap_done_c = c; end
      if (c == cso + 1) cap_first0 = int'(o_bits);
      if (c == cso + 2) cap_first1 = int'(o_bits);
      @(posedge clk); #1;
    end
    ab = 1'b0; st = 1'b0; cur_flip = 1'b0;
    cap_err = int'(o_err); cap_bits = int'(o_bits); cap_sat = o_sat;
    $display("run sel=%0d n=%0d abort_c=%0d: done_cnt=%0d done_c=%0d err=%0d sat=%0d bits=%0d busy_bad=%0d tx_bad=%0d",
             sel, n, abort_c, cap_done_cnt, cap_done_c, cap_err, cap_sat, cap_bits, cap_busy_bad, cap_tx_bad);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if ({tx_m, busy_m, done_m, sat_m} !== 4'b0) begin n_bad++; $display("FAIL reset_flags: got %b want 0000", {tx_m, busy_m, done_m, sat_m}); end
    n_cmp++; if (err_m !== 16'd0 || bits_m !== 16'd0) begin n_bad++; $display("FAIL reset_counts: got err=%0d bits=%0d want 0/0", err_m, bits_m); end
    n_cmp++; if ({tx_s, busy_s, done_s, sat_s, err_s} !== 8'b0 || bits_s !== 16'd0) begin n_bad++; $display("FAIL reset_small: got %b/%0d want 0/0", {tx_s, busy_s, done_s, sat_s, err_s}, bits_s); end
    @(negedge clk); rst = 1'b0;
    $display("reset: outputs checked");
  endtask

  task automatic test_loopback();
    select_dut(0); set_flips(0); model(100, 0);
    run_case(100, 0, 0);
    n_cmp++; if (cap_done_cnt !== 1) begin n_bad++; $display("FAIL loopback done_count: got %0d want 1", cap_done_cnt); end
    n_cmp++; if (cap_done_c !== 24877) begin n_bad++; $display("FAIL loopback done_cycle: got %0d want 24877", cap_done_c); end
    n_cmp++; if (cap_err !== 0 || cap_bits !== 100) begin n_bad++; $display("FAIL loopback counts: got err=%0d bits=%0d want 0/100", cap_err, cap_bits); end
    n_cmp++; if (cap_busy_bad !== 0 || cap_tx_bad !== 0) begin n_bad++; $display("FAIL loopback busy_tx: got %0d/%0d bad cycles want 0/0", cap_busy_bad, cap_tx_bad); end
  endtask

  task automatic test_inverted();
    select_dut(0); set_flips(1); model(10, 0);
    run_case(10, 0, 0);
    n_cmp++; if (cap_err !== 10 || cap_sat !== 1'b0 || cap_bits !== 10) begin n_bad++; $display("FAIL inverted counts: got err=%0d sat=%0d bits=%0d want 10/0/10", cap_err, cap_sat, cap_bits); end
    n_cmp++; if (cap_first0 !== 0 || cap_first1 !== 1) begin n_bad++; $display("FAIL inverted first_sample: got bits %0d@t+126 %0d@t+127 want 0/1", cap_first0, cap_first1); end
    n_cmp++; if (cap_done_c !== exp_done_c || cap_done_cnt !== 1) begin n_bad++; $display("FAIL inverted done: got cycle %0d count %0d want %0d/1", cap_done_c, cap_done_cnt, exp_done_c); end
    n_cmp++; if (cap_busy_bad !== 0 || cap_tx_bad !== 0) begin n_bad++; $display("FAIL inverted busy_tx: got %0d/%0d want 0/0", cap_busy_bad, cap_tx_bad); end
  endtask

  task automatic test_zero_bits();
    select_dut(0); set_flips(1); model(0, 0);
    run_case(0, 0, 0);
    n_cmp++; if (cap_done_c !== 1 || cap_done_cnt !== 1) begin n_bad++; $display("FAIL zero done: got cycle %0d count %0d want 1/1", cap_done_c, cap_done_cnt); end
    n_cmp++; if (cap_busy_bad !== 0 || cap_tx_bad !== 0) begin n_bad++; $display("FAIL zero busy_tx: got %0d/%0d want 0/0", cap_busy_bad, cap_tx_bad); end
    n_cmp++; if (cap_err !== 0 || cap_bits !== 0) begin n_bad++; $display("FAIL zero counts: got err=%0d bits=%0d want 0/0", cap_err, cap_bits); end
  endtask

  task automatic test_abort();
    int ac;
    select_dut(0); set_flips(1);
    ac = 1 + 4 * BC + SO + 1;  // cycle right after the 5th sample
    model(10, ac);
    run_case(10, ac, BC + 7);
    n_cmp++; if (cap_err !== 5 || cap_bits !== 5) begin n_bad++; $display("FAIL abort counts: got err=%0d bits=%0d want 5/5", cap_err, cap_bits); end
    n_cmp++; if (cap_done_cnt !== 0) begin n_bad++; $display("FAIL abort done: got %0d pulses want 0", cap_done_cnt); end
    n_cmp++; if (cap_busy_bad !== 0 || cap_tx_bad !== 0) begin n_bad++; $display("FAIL abort busy_tx: got %0d/%0d want 0/0", cap_busy_bad, cap_tx_bad); end
    // abort on the same cycle as the final sample: that sample is dropped
    set_flips(1);
    ac = 1 + 2 * BC + SO;
    model(3, ac);
    run_case(3, ac, 0);
    n_cmp++; if (cap_bits !== 2 || cap_err !== 2 || cap_done_cnt !== 0) begin n_bad++; $display("FAIL abort_final: got bits=%0d err=%0d done=%0d want 2/2/0", cap_bits, cap_err, cap_done_cnt); end
  endtask

  task automatic test_saturate();
    select_dut(1); set_flips(1); model(20, 0);
    run_case(20, 0, 0);
    n_cmp++; if (cap_err !== 15 || cap_sat !== 1'b1 || cap_bits !== 20) begin n_bad++; $display("FAIL saturate counts: got err=%0d sat=%0d bits=%0d want 15/1/20", cap_err, cap_sat, cap_bits); end
    n_cmp++; if (cap_done_c !== 59 || cap_done_cnt !== 1) begin n_bad++; $display("FAIL saturate done: got cycle %0d count %0d want 59/1", cap_done_c, cap_done_cnt); end
    n_cmp++; if (cap_busy_bad !== 0 || cap_tx_bad !== 0) begin n_bad++; $display("FAIL saturate busy_tx: got %0d/%0d want 0/0", cap_busy_bad, cap_tx_bad); end
  endtask

  task automatic test_random();
    int n, dc, ac, sc;
    for (int it = 0; it < 7; it++) begin
      select_dut(it >= 3);
      n  = (it >= 3) ? int'($urandom_range(10, 40)) : int'($urandom_range(1, 5));
      dc = 2 + (n - 1) * cbc + cso;
      ac = ($urandom_range(0, 1) == 1) ? int'($urandom_range(3, dc - 1)) : 0;
      sc = int'($urandom_range(2, ((ac != 0) ? ac : dc) - 1));
      set_flips(2); model(n, ac);
      run_case(n, ac, sc);
      n_cmp++; if (cap_err !== exp_err || cap_sat !== exp_sat) begin n_bad++; $display("FAIL random%0d err: got %0d/%0d want %0d/%0d", it, cap_err, cap_sat, exp_err, exp_sat); end
      n_cmp++; if (cap_bits !== exp_bits) begin n_bad++; $display("FAIL random%0d bits: got %0d want %0d", it, cap_bits, exp_bits); end
      n_cmp++; if (cap_done_cnt !== exp_done_cnt) begin n_bad++; $display("FAIL random%0d done_count: got %0d want %0d", it, cap_done_cnt, exp_done_cnt); end
      if (exp_done_cnt == 1) begin
        n_cmp++; if (cap_done_c !== exp_done_c) begin n_bad++; $display("FAIL random%0d done_cycle: got %0d want %0d", it, cap_done_c, exp_done_c); end
      end
      n_cmp++; if (cap_busy_bad !== 0 || cap_tx_bad !== 0) begin n_bad++; $display("FAIL random%0d busy_tx: got %0d/%0d want 0/0", it, cap_busy_bad, cap_tx_bad); end
    end
  endtask

  task automatic test_rst_midrun();
    select_dut(0); set_flips(1);
    @(posedge clk); #1;
    st = 1'b1; nb = 16'd10; cur_flip = 1'b1;
    @(posedge clk); #1;
    st = 1'b0;
    repeat (2 * BC + SO + 5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_cmp++; if ({tx_m, busy_m, done_m, sat_m} !== 4'b0 || err_m !== 16'd0 || bits_m !== 16'd0) begin n_bad++; $display("FAIL rst_midrun: got flags=%b err=%0d bits=%0d want all 0", {tx_m, busy_m, done_m, sat_m}, err_m, bits_m); end
    @(negedge clk); rst = 1'b0; cur_flip = 1'b0;
    $display("rst_midrun: outputs after async reset err=%0d bits=%0d", err_m, bits_m);
    set_flips(0); model(2, 0);
    run_case(2, 0, 0);
    n_cmp++; if (cap_bits !== 2 || cap_err !== 0 || cap_done_c !== exp_done_c) begin n_bad++; $display("FAIL rst_rerun: got bits=%0d err=%0d done_c=%0d want 2/0/%0d", cap_bits, cap_err, cap_done_c, exp_done_c); end
    n_cmp++; if (cap_busy_bad !== 0 || cap_tx_bad !== 0) begin n_bad++; $display("FAIL rst_rerun busy_tx: got %0d/%0d want 0/0", cap_busy_bad, cap_tx_bad); end
  endtask

  initial begin
    build_pattern();
    select_dut(0);
    test_reset();
    test_loopback();
    test_inverted();
    test_zero_bits();
    test_abort();
    test_saturate();
    test_random();
    test_rst_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
